// File: rtl/tx_resp_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tx_resp_arbiter                                                |
// | Desc    : Buffers ALU / RegFile / status responses, arbitrates them and  |
// |           serialises bytes into the Tx synchronizer handshake.           |
// |           Build option TX_ARB_FIXED_PRIO_EN: fixed STAT > RD > ALU.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tx_resp_arbiter #(
  parameter int width     = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [2*width-1:0]   ALU_out,
  input  logic                 ALU_valid,
  input  logic [width-1:0]     RD_out,
  input  logic                 RD_valid,
  input  logic [width-1:0]     Stat_code,
  input  logic                 Stat_valid,
  input  logic                 can_send,
  output logic [width-1:0]     Tx_Data,
  output logic                 Tx_valid,
  output logic [2:0]           Overflow,
  output logic                 Timeout,
  output logic                 Idle
);

  localparam logic [1:0] c_ALU     = 2'd0;
  localparam logic [1:0] c_RD      = 2'd1;
  localparam logic [1:0] c_STAT    = 2'd2;
  localparam logic [7:0] c_TO_LAST = 8'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACK  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [2*width-1:0]    r_alu_buf;
  logic [width-1:0]      r_rd_buf;
  logic [width-1:0]      r_stat_buf;
  logic [2:0]            r_pend;
  logic [1:0]            r_grant;
  logic                  r_hi_left;
  logic [7:0]            r_to_cnt;
  logic [width-1:0]      r_tx_data;
  logic                  r_tx_valid;
  logic [2:0]            r_ovf;
  logic                  r_timeout;
`ifndef TX_ARB_FIXED_PRIO_EN
  logic [1:0]            r_ptr;
  logic [1:0]            w_cand;
`endif

  logic [2:0]            w_strobe;
  logic [2:0]            w_release;
  logic [2:0]            w_free;
  logic [2:0]            w_load;
  logic                  w_done;
  logic                  w_to_hit;
  logic                  w_gnt_ok;
  logic [1:0]            w_gnt_idx;
  logic [width-1:0]      w_first_byte;

  assign w_strobe = {Stat_valid, RD_valid, ALU_valid};

  // A response is released either on normal completion or on handshake timeout.
  assign w_done    = (r_state == S_WAIT_DONE) && can_send && !r_hi_left;
  assign w_to_hit  = (r_state == S_WAIT_ACK) && can_send && (r_to_cnt == c_TO_LAST);
  assign w_release = (w_done || w_to_hit) ? (3'b001 << r_grant) : 3'b000;

  // A buffer being released this cycle may accept a new strobe without overflow.
  assign w_free = ~r_pend | w_release;
  assign w_load = w_strobe & w_free;

`ifndef TX_ARB_FIXED_PRIO_EN
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == c_STAT) ? c_ALU : s + 2'd1;
  endfunction
`endif

  always_comb begin
    w_gnt_ok  = 1'b0;
    w_gnt_idx = c_ALU;
`ifdef TX_ARB_FIXED_PRIO_EN
    if (r_pend[c_STAT]) begin
      w_gnt_ok  = 1'b1;
      w_gnt_idx = c_STAT;
    end else if (r_pend[c_RD]) begin
      w_gnt_ok  = 1'b1;
      w_gnt_idx = c_RD;
    end else if (r_pend[c_ALU]) begin
      w_gnt_ok  = 1'b1;
      w_gnt_idx = c_ALU;
    end
`else
    w_cand = next_src(r_ptr);
    for (int i = 0; i < 3; i++) begin
      if (!w_gnt_ok && r_pend[w_cand]) begin
        w_gnt_ok  = 1'b1;
        w_gnt_idx = w_cand;
      end
      w_cand = next_src(w_cand);
    end
`endif
  end

  always_comb begin
    case (w_gnt_idx)
      c_RD:    w_first_byte = r_rd_buf;
      c_STAT:  w_first_byte = r_stat_buf;
      default: w_first_byte = r_alu_buf[width-1:0];
    endcase
  end

  // Response buffers, pending bits and sticky overflow flags.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_alu_buf  <= '0;
      r_rd_buf   <= '0;
      r_stat_buf <= '0;
      r_pend     <= 3'b000;
      r_ovf      <= 3'b000;
    end else begin
      if (w_load[0]) r_alu_buf  <= ALU_out;
      if (w_load[1]) r_rd_buf   <= RD_out;
      if (w_load[2]) r_stat_buf <= Stat_code;
      r_pend <= (r_pend & ~w_release) | w_strobe;
      r_ovf  <= r_ovf | (w_strobe & ~w_free);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_grant    <= c_ALU;
      r_hi_left  <= 1'b0;
      r_to_cnt   <= 8'd0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_timeout  <= 1'b0;
`ifndef TX_ARB_FIXED_PRIO_EN
      r_ptr      <= c_STAT;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_ok && can_send) begin
            r_grant    <= w_gnt_idx;
            r_tx_data  <= w_first_byte;
            r_tx_valid <= 1'b1;
            r_hi_left  <= (w_gnt_idx == c_ALU);
            r_to_cnt   <= 8'd0;
            r_state    <= S_WAIT_ACK;
`ifndef TX_ARB_FIXED_PRIO_EN
            r_ptr      <= w_gnt_idx;
`endif
          end
        end
        S_WAIT_ACK: begin
          if (!can_send) begin
            r_state <= S_WAIT_DONE;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_hi_left <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (can_send) begin
            if (r_hi_left) begin
              r_tx_data  <= r_alu_buf[2*width-1:width];
              r_tx_valid <= 1'b1;
              r_hi_left  <= 1'b0;
              r_to_cnt   <= 8'd0;
              r_state    <= S_WAIT_ACK;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Tx_Data  = r_tx_data;
  assign Tx_valid = r_tx_valid;
  assign Overflow = r_ovf;
  assign Timeout  = r_timeout;
  assign Idle     = (r_state == S_IDLE) && (r_pend == 3'b000);

endmodule
`default_nettype wire

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Arbitrates the UART transmit path between three response producers in the REF_CLK domain: ALU results, register-file read data and status codes. It buffers one pending response per source and serialises each response into bytes. It also sequences the byte handshake toward the Tx data synchronizer using the synchronized `can_send` indication. It sits between the ALU/RegFile outputs and the REF-to-Tx data synchronizer, replacing a direct FIFO feed.

## Interface
- `width`, 8, data byte width; ALU result is `2*width`
- `TO_CYCLES`, 255, maximum cycles to wait for `can_send` to drop after an issue

- `CLK` input 1: REF_CLK domain clock
- `Reset` input 1: asynchronous, active-low reset
- `ALU_out` input 2*width: ALU result
- `ALU_valid` input 1: single-cycle strobe qualifying `ALU_out`
- `RD_out` input width: register-file read data
- `RD_valid` input 1: single-cycle strobe qualifying `RD_out`
- `Stat_code` input width: status/error code
- `Stat_valid` input 1: single-cycle strobe qualifying `Stat_code`
- `can_send` input 1: UART ready for a new byte, already synchronized to CLK
- `Tx_Data` output width: byte to transmit, stable from issue until the next issue
- `Tx_valid` output 1: one-cycle issue pulse
- `Overflow` output 3: sticky per-source drop flags, bit0 ALU, bit1 RD, bit2 STAT
- `Timeout` output 1: sticky; handshake timed out at least once
- `Idle` output 1: no pending buffers and FSM in IDLE

## Operation
- Each source has a one-entry buffer with a pending bit. A strobe loads the buffer when it is not pending.
- A strobe while the buffer is pending drops the new data and sets the source's `Overflow` bit. Overflow bits clear only on reset.
- If a buffer is released and strobed in the same cycle, the new data is loaded and no overflow is flagged.
- Byte counts: ALU response is 2 bytes, low byte first, then `ALU_out[2*width-1:width]`. RD and STAT responses are 1 byte each.
- A grant is locked for the whole response. No interleaving of bytes from different sources.
- Arbitration is round-robin over order ALU→RD→STAT. The search starts at the source after the last granted one. The pointer resets to STAT, so ALU is first after reset.
- FSM states:
  - IDLE: if any buffer is pending and `can_send`=1, grant a source, load `Tx_Data`, pulse `Tx_valid` next cycle, and go to WAIT_ACK.
  - WAIT_ACK: when `can_send`=0, go to WAIT_DONE. If `TO_CYCLES` elapse without that, set `Timeout`, release the grant, drop the response, and go to IDLE.
  - WAIT_DONE: when `can_send`=1:
    - If bytes remain, load the next byte, pulse `Tx_valid`, and go to WAIT_ACK.
    - Otherwise clear the granted pending bit and go to IDLE.
- Reset mid-operation: all buffers, pending bits, FSM, pointer and flags clear immediately. No partial response is resumed.

## Timing
- Reset values: `Tx_Data`=0, `Tx_valid`=0, `Overflow`=0, `Timeout`=0, `Idle`=1.
- Strobe to pending: 1 cycle (registered).
- Pending with `can_send`=1 in IDLE: `Tx_valid` is high exactly 1 cycle later, and `Tx_Data` is valid in the same cycle.
- `Tx_valid` is never high for 2 consecutive cycles. It is never asserted while `can_send`=0.
- Release happens in the cycle WAIT_DONE sees `can_send`=1. A newly pending source can be issued from IDLE 1 cycle later.
- The timeout counter is 8 bits. It counts cycles spent in WAIT_ACK and resets on every entry to WAIT_ACK.

## Configuration
- `TX_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority STAT > RD > ALU, and the round-robin pointer is not implemented.
  - Undefined: round-robin as specified above.
- All other behaviour is identical with or without the macro.

## Test plan
- ALU_valid with `ALU_out`=16'hA55A and a `can_send` toggle model → `Tx_Data` 8'h5A then 8'hA5, two `Tx_valid` pulses, then `Idle`=1.
- RD_valid (8'h3C) and Stat_valid (8'hE1) in the same cycle, after an ALU grant → issue order 3C, E1. With `TX_ARB_FIXED_PRIO_EN` the order is E1, 3C.
- Two RD_valid strobes 3 cycles apart while `can_send`=0 → first byte sent, `Overflow`=3'b010, second byte never sent.
- `can_send` held high after an issue → after 255 cycles `Timeout`=1, FSM returns to IDLE, next pending source is issued.
- Reset asserted between the ALU low and high bytes → all outputs at reset values. After release with `can_send`=1 and no new strobes, no `Tx_valid` occurs.
- RD_valid in the same cycle the RD buffer releases → new data is accepted, `Overflow`=0, and the byte is issued next.
